// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer wrapped around an external full_adder cell.
// Operands are fed LSB first into the cell through fa_a/fa_b/fa_cin. The
// cell's sum and carry come back on fa_s/fa_cout. After WIDTH shift cycles
// the WIDTH-bit sum, carry-out and signed overflow are presented with a
// one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] sum_sh_next;
    logic             last_bit;

    // Sum shift register: the new sum bit enters at the MSB so that after
    // WIDTH shifts the LSB-first stream lands in natural bit order.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_sh_next = fa_s;
        end else begin : g_sum_wn
            assign sum_sh_next = {fa_s, sum_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Cell inputs are driven only while shifting; busy_reg is high exactly
    // in SHIFT, so the gating keeps fa_* at 0 in IDLE and DONE.
    assign fa_a   = busy_reg & a_sh_reg[0];
    assign fa_b   = busy_reg & b_sh_reg[0];
    assign fa_cin = busy_reg & carry_reg;

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    // Sequencer FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            sum_sh_reg   <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // DONE lasts one cycle; it accepts a new start exactly
                    // like IDLE so operations can run back to back.
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        carry_reg  <= cin;
                        sum_sh_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                SHIFT: begin
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= fa_cout;
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        // On the MSB cycle carry_reg still holds the carry
                        // into the MSB and fa_cout is the carry out of it,
                        // so overflow is resolved here and all results are
                        // published together with the done pulse.
                        sum_reg      <= sum_sh_next;
                        cout_reg     <= fa_cout;
                        overflow_reg <= carry_reg ^ fa_cout;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= DONE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: one WIDTH=4 and one WIDTH=1 instance,
// each closed with a behavioural full adder, checked against an arithmetic
// reference model of a+b+cin and signed overflow.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // WIDTH=4 instance
    logic       start4, cin4;
    logic [3:0] a4, b4;
    logic       fa_a4, fa_b4, fa_cin4, fa_s4, fa_cout4;
    logic [3:0] sum4;
    logic       cout4, ovf4, busy4, done4;

    // WIDTH=1 instance
    logic       start1, cin1;
    logic [0:0] a1, b1;
    logic       fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
    logic [0:0] sum1;
    logic       cout1, ovf1, busy1, done1;

    assign fa_s4    = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);
    assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_s(fa_s4), .fa_cout(fa_cout4),
        .sum(sum4), .cout(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1),
        .sum(sum1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum, plus signed-range test for overflow.
    task automatic model(input int w, input int av, input int bv, input int cv,
                         output int es, output int eco, output int eov);
        int total, half, sa, sb, ss;
        total = av + bv + cv;
        es    = total % (1 << w);
        eco   = total >> w;
        half  = 1 << (w - 1);
        sa    = (av >= half) ? av - (1 << w) : av;
        sb    = (bv >= half) ? bv - (1 << w) : bv;
        ss    = sa + sb + cv;
        eov   = (ss < -half || ss > half - 1) ? 1 : 0;
    endtask

    // Issues one start on the selected instance (0: WIDTH=4, 1: WIDTH=1) and
    // returns results in the done cycle, the cycles from accept to done,
    // the busy cycle count and the fa_a stream seen while busy.
    task automatic run_op(input int sel, input int av, input int bv, input int cv,
                          output int s, output int co, output int ov,
                          output int lat, output int nbusy, output logic [15:0] faseq);
        if (sel == 0) begin
            a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv[0]; start4 = 1'b1;
        end else begin
            a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv[0]; start1 = 1'b1;
        end
        tick();
        start4 = 1'b0;
        start1 = 1'b0;
        lat    = 0;
        nbusy  = 0;
        faseq  = '0;
        while (((sel == 0) ? done4 : done1) !== 1'b1 && lat < 20) begin
            if (((sel == 0) ? busy4 : busy1) === 1'b1 && nbusy < 16) begin
                faseq[nbusy] = (sel == 0) ? fa_a4 : fa_a1;
                nbusy++;
            end
            tick();
            lat++;
        end
        s  = (sel == 0) ? int'(sum4) : int'(sum1);
        co = (sel == 0) ? int'(cout4) : int'(cout1);
        ov = (sel == 0) ? int'(ovf4) : int'(ovf1);
        $display("op w=%0d a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d ovf=%0d lat=%0d",
                 (sel == 0) ? 4 : 1, av, bv, cv, s, co, ov, lat);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start4 = 1'b1;   // reset must win over start
        start1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick();
        tick();
        checks++;
        if ({sum4, cout4, ovf4, busy4, done4, fa_a4, fa_b4, fa_cin4} !== 11'b0) begin
            $display("FAIL reset_w4: got sum=%0d cout=%b ovf=%b busy=%b done=%b fa=%b%b%b, need all 0",
                     sum4, cout4, ovf4, busy4, done4, fa_a4, fa_b4, fa_cin4);
        end else passed++;
        checks++;
        if ({sum1, cout1, ovf1, busy1, done1, fa_a1, fa_b1, fa_cin1} !== 8'b0) begin
            $display("FAIL reset_w1: got sum=%0d cout=%b ovf=%b busy=%b done=%b, need all 0",
                     sum1, cout1, ovf1, busy1, done1);
        end else passed++;
        reset  = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        tick();
        checks++;
        if (busy4 !== 1'b0 || busy1 !== 1'b0) begin
            $display("FAIL reset_start_dropped: got busy4=%b busy1=%b, need 0", busy4, busy1);
        end else passed++;
    endtask

    task automatic test_basic();
        int av[3] = '{3, 15, 7};
        int bv[3] = '{5, 1, 0};
        int cv[3] = '{0, 0, 1};
        int s, co, ov, lat, nb, es, eco, eov;
        logic [15:0] fs;
        for (int i = 0; i < 3; i++) begin
            run_op(0, av[i], bv[i], cv[i], s, co, ov, lat, nb, fs);
            model(4, av[i], bv[i], cv[i], es, eco, eov);
            checks++;
            if (s !== es || co !== eco || ov !== eov) begin
                $display("FAIL basic_result a=%0d b=%0d cin=%0d: got %0d/%0d/%0d, need %0d/%0d/%0d",
                         av[i], bv[i], cv[i], s, co, ov, es, eco, eov);
            end else passed++;
            checks++;
            if (lat !== 4 || nb !== 4) begin
                $display("FAIL basic_timing: got lat=%0d busy=%0d, need 4/4", lat, nb);
            end else passed++;
            checks++;
            if ({fa_a4, fa_b4, fa_cin4} !== 3'b000) begin
                $display("FAIL basic_fa_idle: got %b%b%b in done cycle, need 000", fa_a4, fa_b4, fa_cin4);
            end else passed++;
            if (i == 0) begin
                checks++;
                if (fs[3:0] !== 4'b0011) begin
                    $display("FAIL basic_fa_a_seq: got %b (bit0 first), need 0011", fs[3:0]);
                end else passed++;
            end
            tick();
            checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || int'(sum4) !== es) begin
                $display("FAIL basic_after_done: got done=%b busy=%b sum=%0d, need 0/0/%0d",
                         done4, busy4, sum4, es);
            end else passed++;
        end
    endtask

    task automatic test_start_ignored();
        int c, nb;
        a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        c  = 1;
        nb = 0;
        while (done4 !== 1'b1 && c < 20) begin
            if (busy4 === 1'b1) nb++;
            if (c == 2) begin
                start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
            end else begin
                start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
            end
            tick();
            c++;
        end
        start4 = 1'b0;
        $display("op w=4 a=2 b=2 cin=0 (start pulsed mid-shift) -> sum=%0d cout=%0d", sum4, cout4);
        checks++;
        if (sum4 !== 4'd4 || cout4 !== 1'b0 || nb !== 4) begin
            $display("FAIL start_ignored: got sum=%0d cout=%b busy=%0d, need 4/0/4", sum4, cout4, nb);
        end else passed++;
        tick();
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            $display("FAIL start_ignored_idle: got busy=%b done=%b, need 0/0", busy4, done4);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int last, ndone;
        a4 = 4'd1; b4 = 4'd1; cin4 = 1'b0; start4 = 1'b1;
        tick();
        last  = 0;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done4 === 1'b1) begin
                checks++;
                if (c - last !== 5 || sum4 !== 4'd2) begin
                    $display("FAIL b2b_done: got gap=%0d sum=%0d, need 5/2", c - last, sum4);
                end else passed++;
                $display("op w=4 a=1 b=1 cin=0 (back-to-back) -> sum=%0d at cycle %0d", sum4, c);
                last = c;
                ndone++;
            end else if (ndone > 0) begin
                checks++;
                if (sum4 !== 4'd2) begin
                    $display("FAIL b2b_hold: got sum=%0d at cycle %0d, need 2", sum4, c);
                end else passed++;
            end
            if (c == 30) start4 = 1'b0;
            tick();
        end
        checks++;
        if (ndone !== 6) begin
            $display("FAIL b2b_count: got %0d done pulses, need 6", ndone);
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int nd;
        a4 = 4'd15; b4 = 4'd15; cin4 = 1'b0; start4 = 1'b1;
        tick();            // SHIFT cycle 1
        start4 = 1'b0;
        tick();            // SHIFT cycle 2
        tick();            // SHIFT cycle 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({sum4, cout4, ovf4, busy4, done4, fa_a4, fa_b4, fa_cin4} !== 11'b0) begin
            $display("FAIL reset_mid: got sum=%0d cout=%b ovf=%b busy=%b done=%b fa=%b%b%b, need all 0",
                     sum4, cout4, ovf4, busy4, done4, fa_a4, fa_b4, fa_cin4);
        end else passed++;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done4 === 1'b1 || busy4 === 1'b1) nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles, need 0", nd);
        end else passed++;
    endtask

    task automatic test_exhaustive();
        int s, co, ov, lat, nb, es, eco, eov;
        logic [15:0] fs;
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int cv = 0; cv < 2; cv++) begin
                    run_op(0, av, bv, cv, s, co, ov, lat, nb, fs);
                    model(4, av, bv, cv, es, eco, eov);
                    checks++;
                    if (s !== es || co !== eco || ov !== eov || lat !== 4) begin
                        $display("FAIL exh_w4 a=%0d b=%0d cin=%0d: got %0d/%0d/%0d lat=%0d, need %0d/%0d/%0d lat=4",
                                 av, bv, cv, s, co, ov, lat, es, eco, eov);
                    end else passed++;
                end
        for (int av = 0; av < 2; av++)
            for (int bv = 0; bv < 2; bv++)
                for (int cv = 0; cv < 2; cv++) begin
                    run_op(1, av, bv, cv, s, co, ov, lat, nb, fs);
                    model(1, av, bv, cv, es, eco, eov);
                    checks++;
                    if (s !== es || co !== eco || ov !== eov || lat !== 1) begin
                        $display("FAIL exh_w1 a=%0d b=%0d cin=%0d: got %0d/%0d/%0d lat=%0d, need %0d/%0d/%0d lat=1",
                                 av, bv, cv, s, co, ov, lat, es, eco, eov);
                    end else passed++;
                end
        tick();
    endtask

    task automatic test_random();
        int av, bv, cv, gap, s, co, ov, lat, nb, es, eco, eov;
        logic [15:0] fs;
        for (int i = 0; i < 40; i++) begin
            av  = int'($urandom_range(15, 0));
            bv  = int'($urandom_range(15, 0));
            cv  = int'($urandom_range(1, 0));
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) tick();
            run_op(0, av, bv, cv, s, co, ov, lat, nb, fs);
            model(4, av, bv, cv, es, eco, eov);
            checks++;
            if (s !== es || co !== eco || ov !== eov || nb !== 4) begin
                $display("FAIL rand a=%0d b=%0d cin=%0d: got %0d/%0d/%0d busy=%0d, need %0d/%0d/%0d busy=4",
                         av, bv, cv, s, co, ov, nb, es, eco, eov);
            end else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add sequencer that sits around a single full_adder cell.
- Each cycle it drives the cell's A/B/Cin from shift registers (LSB first), then captures the cell's S/Cout.
- After WIDTH cycles it presents a WIDTH-bit sum, carry-out and signed overflow flag.
- Serves as the area-minimal alternative to the ripple chain on Basys3; the full_adder instance sits one level up and is wired to the fa_* ports.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a clk edge where high
- start  input  1  request a new addition; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  initial carry-in, latched on accepted start
- fa_a  output  1  to full_adder A
- fa_b  output  1  to full_adder B
- fa_cin  output  1  to full_adder Cin
- fa_s  input  1  from full_adder S (combinational return)
- fa_cout  input  1  from full_adder Cout (combinational return)
- sum  output  WIDTH  result, held stable from done until next accepted start
- cout  output  1  final carry-out
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle pulse when sum/cout/overflow become valid

Behaviour:
- Reset values: sum=0, cout=0, overflow=0, busy=0, done=0, fa_a=fa_b=fa_cin=0, state=IDLE, bit counter=0, internal shift/carry registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> latch a, b, cin into a_sh, b_sh, carry_reg; clear counter and sum_sh; go to SHIFT.
  - start=0 -> stay.
- SHIFT:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_reg (combinational from registers).
  - Each edge: sum_sh shifts right with fa_s entering at MSB; carry_reg<=fa_cout; a_sh, b_sh shift right (zero fill); counter increments.
  - On the edge where counter==WIDTH-1: also capture carry_reg (carry into MSB) into msb_cin_reg; go to DONE.
  - start is ignored in SHIFT; operands are not re-latched.
- DONE (exactly one cycle):
  - done=1; sum=sum_sh; cout=carry_reg; overflow=msb_cin_reg XOR carry_reg.
  - Next state IDLE, or SHIFT if start=1, with latching as in IDLE (back-to-back operation).
- Output registers sum/cout/overflow update only on entry to DONE. They are unchanged in IDLE and during SHIFT of the next operation.
- fa_* are 0 outside SHIFT.
- Latency:
  - start accepted at edge k; SHIFT occupies cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
  - Throughput: one result per WIDTH+1 cycles.
- Arithmetic: result equals (a+b+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum. WIDTH=1 is legal: a single SHIFT cycle, overflow=cin XOR cout.
- Reset mid-operation (any state, including SHIFT and DONE): abort, no done pulse, all outputs to reset values on that edge.
- Reset and start high on the same edge: reset wins; start is dropped.

Test Plan:
- WIDTH=4, a=3, b=5, cin=0, start 1 cycle -> busy high 4 cycles, then done pulse; sum=8, cout=0, overflow=1; fa_a sequence 1,1,0,0.
- a=15, b=1, cin=0 -> sum=0, cout=1, overflow=0; a=7, b=0, cin=1 -> sum=8, cout=0, overflow=1.
- Start a=2, b=2; pulse start with a=9, b=9 during SHIFT cycle 2 -> ignored, result sum=4, cout=0; busy never re-extends.
- start held high continuously with a=1, b=1, cin=0 -> done every 5 cycles, sum=2 each time; sum stable between done pulses.
- reset high in SHIFT cycle 3 of a=15, b=15 -> next cycle busy=0, done never pulses, sum=0, cout=0, overflow=0, fa_*=0.
- Exhaustive check, WIDTH=4: all 512 (a,b,cin) combinations against a behavioural a+b+cin model, including overflow. Also run WIDTH=1 on all 8 combinations.
